alu_wb_master: RTL and testbench
================================

# alu_wb_master

Wishbone pipelined bus master that sits directly upstream of the 8-bit ALU slave. It accepts one arithmetic command (operands plus opcode) on a valid/ready interface and runs a fixed bus sequence against the ALU: write A, write B, trigger the operation, read the result, read the flags. It returns result and flags on a valid/ready response interface, with an ack timeout that reports an error instead of hanging.

## Interface
- ACK_TIMEOUT, 16: max cycles a bus transaction may wait (stall plus ack) before abort; must be ≥2.
- i_clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  block can accept a command.
- i_cmd_op  in  1  0 = add (ALU addr 0x80), 1 = add with carry (ALU addr 0x81).
- i_cmd_a  in  8  operand A.
- i_cmd_b  in  8  operand B.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer takes response.
- o_rsp_result  out  8  ALU result.
- o_rsp_flags  out  8  ALU flags register.
- o_rsp_err  out  1  1 = sequence aborted on timeout.
- o_wb_stb  out  1  bus request strobe.
- o_wb_we  out  1  1 = write.
- o_wb_addr  out  8  bus address.
- o_wb_data  out  8  write data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_stall  in  1  slave cannot accept request.
- i_wb_data  in  8  slave read data.

## Operation
- States: IDLE, WR_A, WR_B, EXEC, RD_RES, RD_FLG, RESP.
- IDLE: o_cmd_ready=1. On i_cmd_valid && o_cmd_ready, latch op/a/b and go to WR_A.
- Bus states run in this order, each with one request followed by an ack wait:
  - WR_A: addr 0x00, we=1, data=a.
  - WR_B: addr 0x01, we=1, data=b.
  - EXEC: addr 0x80+op, we=0, read data discarded.
  - RD_RES: addr 0x03, we=0, data captured into result.
  - RD_FLG: addr 0x02, we=0, data captured into flags.
- Request phase: o_wb_stb=1 with addr/we/data stable until accepted (o_wb_stb && !i_wb_stall).
  - Read data is sampled in the acceptance cycle, because the ALU drives read data combinationally while strobed.
  - o_wb_stb=0 from the next cycle.
- Ack phase: wait for i_wb_ack, then advance to the next state.
  - i_wb_ack seen outside an ack wait is ignored.
  - At most one transaction is outstanding.
- Timeout: counter clears on entry to each bus state and counts every cycle in that state.
  - On reaching ACK_TIMEOUT without ack, drop o_wb_stb, go to RESP with o_rsp_err=1, result=0x00, flags=0x00.
- RESP: o_rsp_valid=1, outputs held stable until i_rsp_ready. Then go to IDLE; o_cmd_ready rises the following cycle.
- o_wb_data=0 when o_wb_we=0. o_wb_addr and o_wb_we are don't-care when o_wb_stb=0 but driven (not Z).

## Timing
- Reset (reset=0, async) values:
  - state IDLE, o_cmd_ready=1.
  - o_rsp_valid=0, o_rsp_result=0x00, o_rsp_flags=0x00, o_rsp_err=0.
  - o_wb_stb=0, o_wb_we=0, o_wb_addr=0x00, o_wb_data=0x00.
  - timeout counter 0.
- Reset mid-sequence: o_wb_stb drops immediately (asynchronously); any pending response is lost.
- Zero-stall, ack-next-cycle slave, command accepted at cycle 0:
  - stb in cycles 1, 3, 5, 7, 9; acks in cycles 2, 4, 6, 8, 10.
  - o_rsp_valid in cycle 11.
- Each stall cycle adds one cycle to the sequence. Each extra ack-delay cycle adds one cycle.
- Commands are ignored while o_cmd_ready=0; a command is never accepted in the same cycle a response is consumed.

## Test plan
- Nominal add: a=0x05, b=0x03, op=0, behavioural ALU slave -> bus writes 0x00←0x05, 0x01←0x03; reads 0x80, 0x03, 0x02; o_rsp_result=0x08, err=0, o_rsp_valid at cycle 11.
- Add with carry: a=0xFF, b=0x00, op=1 -> EXEC address 0x81; o_rsp_result=0x00; o_rsp_flags bit0=1.
- Stall: i_wb_stall=1 for 3 cycles during WR_B -> stb and addr 0x01 held 4 cycles; o_rsp_valid at cycle 14; result unchanged.
- Timeout: ACK_TIMEOUT=4, slave never acks RD_RES -> o_wb_stb low after RD_RES accept; o_rsp_err=1, result=0x00, flags=0x00.
- Response backpressure: i_rsp_ready=0 for 5 cycles -> o_rsp_valid and data stable; o_cmd_ready=0 throughout; o_cmd_ready=1 the cycle after the handshake.
- Reset mid-op: reset asserted while EXEC stb high -> o_wb_stb=0 same cycle; after release all outputs at reset values; a new command completes normally.

Source files
------------

// File: rtl/alu_wb_master.sv
// alu_wb_master: Wishbone pipelined master that drives one ALU operation per
// command (write A, write B, trigger, read result, read flags) and returns the
// result and flags on a valid/ready response channel. Every bus transaction is
// guarded by a cycle timeout so a silent slave turns into an error response
// instead of a hang.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | o_cmd_ready=1, waiting for a command
// WR_A   | write operand A to ALU address 0x00
// WR_B   | write operand B to ALU address 0x01
// EXEC   | read 0x80 (add) or 0x81 (add with carry); data discarded
// RD_RES | read result from 0x03
// RD_FLG | read flags from 0x02
// RESP   | o_rsp_valid=1, outputs held until i_rsp_ready
//
// Each bus state has a request phase (o_wb_stb held until !i_wb_stall) and an
// ack phase (wait_ack=1, o_wb_stb low, waiting for i_wb_ack).
// ACK_TIMEOUT must be at least 2: a zero-wait transaction needs one request
// cycle plus one ack cycle.

module alu_wb_master #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       i_clk,
   input  logic       reset,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic       i_cmd_op,
   input  logic [7:0] i_cmd_a,
   input  logic [7:0] i_cmd_b,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [7:0] o_rsp_result,
   output logic [7:0] o_rsp_flags,
   output logic       o_rsp_err,
   output logic       o_wb_stb,
   output logic       o_wb_we,
   output logic [7:0] o_wb_addr,
   output logic [7:0] o_wb_data,
   input  logic       i_wb_ack,
   input  logic       i_wb_stall,
   input  logic [7:0] i_wb_data
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_A   = 3'd1,
      WR_B   = 3'd2,
      EXEC   = 3'd3,
      RD_RES = 3'd4,
      RD_FLG = 3'd5,
      RESP   = 3'd6
   } state_t;

   // Down-counter: loaded with ACK_TIMEOUT-1 on entry to a bus state, so the
   // terminal count (zero) is reached in the ACK_TIMEOUT-th cycle of the state.
   localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT - 1);

   state_t        state;
   logic          wait_ack;
   logic [TW-1:0] tmo_cnt;
   logic          op_q;
   logic [7:0]    a_q;
   logic [7:0]    b_q;
   logic [7:0]    res_q;
   logic [7:0]    flg_q;

   logic          req_accept;
   logic          tmo_hit;

   assign req_accept = o_wb_stb && !i_wb_stall;
   assign tmo_hit    = (tmo_cnt == '0);

   function automatic state_t next_bus(input state_t st);
      case (st)
         WR_A:    next_bus = WR_B;
         WR_B:    next_bus = EXEC;
         EXEC:    next_bus = RD_RES;
         RD_RES:  next_bus = RD_FLG;
         default: next_bus = RESP;
      endcase
   endfunction

   function automatic logic [7:0] req_addr(input state_t st, input logic op);
      case (st)
         WR_A:    req_addr = 8'h00;
         WR_B:    req_addr = 8'h01;
         EXEC:    req_addr = {7'b1000000, op};
         RD_RES:  req_addr = 8'h03;
         RD_FLG:  req_addr = 8'h02;
         default: req_addr = 8'h00;
      endcase
   endfunction

   function automatic logic req_we(input state_t st);
      req_we = (st == WR_A) || (st == WR_B);
   endfunction

   // Write data is forced to zero for reads so o_wb_data=0 whenever we=0.
   function automatic logic [7:0] req_wdata(input state_t st,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
      case (st)
         WR_A:    req_wdata = a;
         WR_B:    req_wdata = b;
         default: req_wdata = 8'h00;
      endcase
   endfunction

   // Sequencer FSM with registered bus and handshake outputs.
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         wait_ack     <= 1'b0;
         tmo_cnt      <= '0;
         op_q         <= 1'b0;
         a_q          <= 8'h00;
         b_q          <= 8'h00;
         res_q        <= 8'h00;
         flg_q        <= 8'h00;
         o_cmd_ready  <= 1'b1;
         o_rsp_valid  <= 1'b0;
         o_rsp_result <= 8'h00;
         o_rsp_flags  <= 8'h00;
         o_rsp_err    <= 1'b0;
         o_wb_stb     <= 1'b0;
         o_wb_we      <= 1'b0;
         o_wb_addr    <= 8'h00;
         o_wb_data    <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (i_cmd_valid && o_cmd_ready) begin
                  op_q        <= i_cmd_op;
                  a_q         <= i_cmd_a;
                  b_q         <= i_cmd_b;
                  o_cmd_ready <= 1'b0;
                  state       <= WR_A;
                  wait_ack    <= 1'b0;
                  tmo_cnt     <= TMO_LOAD;
                  o_wb_stb    <= 1'b1;
                  o_wb_we     <= req_we(WR_A);
                  o_wb_addr   <= req_addr(WR_A, i_cmd_op);
                  o_wb_data   <= req_wdata(WR_A, i_cmd_a, i_cmd_b);
               end
            end

            RESP: begin
               // The cycle after the handshake is IDLE with o_cmd_ready=1, so
               // a command can never be taken in the consuming cycle.
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_cmd_ready <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               if (wait_ack && i_wb_ack) begin
                  if (state == RD_FLG) begin
                     state        <= RESP;
                     wait_ack     <= 1'b0;
                     o_rsp_valid  <= 1'b1;
                     o_rsp_result <= res_q;
                     o_rsp_flags  <= flg_q;
                     o_rsp_err    <= 1'b0;
                  end else begin
                     state     <= next_bus(state);
                     wait_ack  <= 1'b0;
                     tmo_cnt   <= TMO_LOAD;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= req_we(next_bus(state));
                     o_wb_addr <= req_addr(next_bus(state), op_q);
                     o_wb_data <= req_wdata(next_bus(state), a_q, b_q);
                  end
               end else if (tmo_hit) begin
                  // Out of budget: an acceptance in this very cycle is also
                  // abandoned, since no cycle is left for its ack.
                  state        <= RESP;
                  wait_ack     <= 1'b0;
                  o_wb_stb     <= 1'b0;
                  o_wb_we      <= 1'b0;
                  o_wb_data    <= 8'h00;
                  o_rsp_valid  <= 1'b1;
                  o_rsp_result <= 8'h00;
                  o_rsp_flags  <= 8'h00;
                  o_rsp_err    <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt - TW'(1);
                  if (req_accept) begin
                     // The ALU drives read data combinationally while
                     // strobed, so it is captured in the acceptance cycle.
                     o_wb_stb <= 1'b0;
                     wait_ack <= 1'b1;
                     if (state == RD_RES) res_q <= i_wb_data;
                     if (state == RD_FLG) flg_q <= i_wb_data;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_wb_master.sv
// Bench for alu_wb_master: behavioural ALU slave with per-transaction stall and
// ack-delay plans, expected bus transaction queue, arithmetic reference model,
// table vectors, random commands, reset mid-operation, and a second instance
// with ACK_TIMEOUT=4 for the timeout path.

module tb_alu_wb_master;

   logic       i_clk = 1'b0;
   logic       reset;
   logic       i_cmd_valid, i_cmd_op, o_cmd_ready;
   logic [7:0] i_cmd_a, i_cmd_b;
   logic       o_rsp_valid, i_rsp_ready, o_rsp_err;
   logic [7:0] o_rsp_result, o_rsp_flags;
   logic       o_wb_stb, o_wb_we, i_wb_ack, i_wb_stall;
   logic [7:0] o_wb_addr, o_wb_data, i_wb_data;

   logic       t_cmd_valid, t_cmd_op, t_cmd_ready;
   logic [7:0] t_cmd_a, t_cmd_b;
   logic       t_rsp_valid, t_rsp_ready, t_rsp_err;
   logic [7:0] t_rsp_result, t_rsp_flags;
   logic       t_stb, t_we, t_ack, t_stall;
   logic [7:0] t_addr, t_wdata, t_rdata;

   always #5 i_clk = ~i_clk;

   alu_wb_master dut (
      .i_clk(i_clk), .reset(reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
      .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_result(o_rsp_result), .o_rsp_flags(o_rsp_flags), .o_rsp_err(o_rsp_err),
      .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
      .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
      .i_wb_data(i_wb_data)
   );

   alu_wb_master #(.ACK_TIMEOUT(4)) dut4 (
      .i_clk(i_clk), .reset(reset),
      .i_cmd_valid(t_cmd_valid), .o_cmd_ready(t_cmd_ready), .i_cmd_op(t_cmd_op),
      .i_cmd_a(t_cmd_a), .i_cmd_b(t_cmd_b),
      .o_rsp_valid(t_rsp_valid), .i_rsp_ready(t_rsp_ready),
      .o_rsp_result(t_rsp_result), .o_rsp_flags(t_rsp_flags), .o_rsp_err(t_rsp_err),
      .o_wb_stb(t_stb), .o_wb_we(t_we), .o_wb_addr(t_addr),
      .o_wb_data(t_wdata), .i_wb_ack(t_ack), .i_wb_stall(t_stall),
      .i_wb_data(t_rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural ALU slave ----------------
   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   txn_t       exp_q[$];
   int         stall_plan[5];
   int         delay_plan[5];
   int         txn_idx = 0;
   bit         in_req = 0;
   int         stall_left = 0;
   bit         ack_pend = 0;
   int         ack_cyc = 0;
   logic [7:0] s_a = 8'h00, s_b = 8'h00, s_res = 8'h00, s_flg = 8'h00;

   function automatic logic [7:0] slave_rd(input logic [7:0] addr);
      case (addr)
         8'h00:   return s_a;
         8'h01:   return s_b;
         8'h02:   return s_flg;
         8'h03:   return s_res;
         default: return 8'h00;
      endcase
   endfunction

   task automatic slave_accept();
      txn_t       e;
      logic [8:0] sum;
      if (o_wb_we) begin
         if (o_wb_addr == 8'h00) s_a = o_wb_data;
         if (o_wb_addr == 8'h01) s_b = o_wb_data;
      end else if (o_wb_addr[7]) begin
         sum   = {1'b0, s_a} + {1'b0, s_b} + {8'h00, o_wb_addr[0] & s_flg[0]};
         s_res = sum[7:0];
         s_flg = {6'b0, sum[7:0] == 8'h00, sum[8]};
      end
      if (exp_q.size() == 0) begin
         check("bus_unexpected_txn", {16'h0, o_wb_we, o_wb_addr}, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check("bus_we", o_wb_we, e.we);
         check("bus_addr", o_wb_addr, e.addr);
         check("bus_wdata", o_wb_data, e.data);
      end
   endtask

   // Slave acts on the falling edge: what it sees then is what the master
   // presents for the whole cycle, and what it drives is sampled next rise.
   initial begin
      i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 8'h00;
      forever begin
         @(negedge i_clk);
         if (!reset) begin
            in_req = 0; ack_pend = 0;
            i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 8'h00;
         end else begin
            i_wb_ack = 1'b0;
            if (ack_pend && cyc == ack_cyc) begin
               i_wb_ack = 1'b1;
               ack_pend = 0;
            end
            i_wb_stall = 1'b0;
            i_wb_data  = 8'h00;
            if (o_wb_stb) begin
               if (!in_req) begin
                  in_req     = 1;
                  stall_left = (txn_idx < 5) ? stall_plan[txn_idx] : 0;
               end
               if (!o_wb_we) i_wb_data = slave_rd(o_wb_addr);
               if (stall_left > 0) begin
                  i_wb_stall = 1'b1;
                  stall_left--;
               end else begin
                  slave_accept();
                  in_req   = 0;
                  ack_pend = 1;
                  ack_cyc  = cyc + 1 + ((txn_idx < 5) ? delay_plan[txn_idx] : 0);
                  txn_idx++;
               end
            end
         end
      end
   end

   // Slave for the ACK_TIMEOUT=4 instance: never stalls, acks the cycle after
   // acceptance, and can be told to swallow the ack of the result read.
   bit t_acc_prev  = 0;
   bit t_block_res = 0;
   initial begin
      t_ack = 1'b0; t_stall = 1'b0; t_rdata = 8'h5A;
      forever begin
         @(negedge i_clk);
         if (!reset) begin
            t_ack = 1'b0; t_acc_prev = 0;
         end else begin
            t_ack      = t_acc_prev;
            t_acc_prev = t_stb && !(t_block_res && t_addr == 8'h03);
         end
      end
   end

   // ---------------- reference model ----------------
   logic m_c = 1'b0;

   task automatic model_cmd(input logic op, input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r, output logic [7:0] f);
      logic [8:0] s;
      s   = {1'b0, a} + {1'b0, b} + {8'h00, op & m_c};
      r   = s[7:0];
      f   = {6'b0, s[7:0] == 8'h00, s[8]};
      m_c = s[8];
   endtask

   task automatic push_exp(input logic op, input logic [7:0] a, input logic [7:0] b);
      exp_q.push_back('{1'b1, 8'h00, a});
      exp_q.push_back('{1'b1, 8'h01, b});
      exp_q.push_back('{1'b0, {7'b1000000, op}, 8'h00});
      exp_q.push_back('{1'b0, 8'h03, 8'h00});
      exp_q.push_back('{1'b0, 8'h02, 8'h00});
   endtask

   task automatic set_plan(input int s_idx, input int s_n, input int d_idx, input int d_n);
      for (int i = 0; i < 5; i++) begin
         stall_plan[i] = 0;
         delay_plan[i] = 0;
      end
      if (s_idx >= 0) stall_plan[s_idx] = s_n;
      if (d_idx >= 0) delay_plan[d_idx] = d_n;
   endtask

   // One full command on the main instance, checked for bus order, latency,
   // response content, backpressure stability and the ready handshake.
   task automatic run_cmd(input logic op, input logic [7:0] a, input logic [7:0] b,
                          input int bp, input bit junk,
                          input logic [7:0] er, input logic [7:0] ef, input int lat);
      int t0;
      int n;
      @(negedge i_clk);
      check("cmd_ready_idle", o_cmd_ready, 1'b1);
      txn_idx = 0;
      push_exp(op, a, b);
      i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_a = a; i_cmd_b = b;
      t0 = cyc;
      @(negedge i_clk);
      check("cmd_ready_busy", o_cmd_ready, 1'b0);
      if (junk) begin
         i_cmd_valid = 1'b1; i_cmd_op = ~op; i_cmd_a = ~a; i_cmd_b = ~b;
      end else begin
         i_cmd_valid = 1'b0;
      end
      n = 0;
      while (!o_rsp_valid && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      i_cmd_valid = 1'b0;
      if (!o_rsp_valid) begin
         check("rsp_never_valid", o_rsp_valid, 1'b1);
         exp_q.delete();
         return;
      end
      check("rsp_latency", cyc - t0, lat);
      check("rsp_result", o_rsp_result, er);
      check("rsp_flags", o_rsp_flags, ef);
      check("rsp_err", o_rsp_err, 1'b0);
      check("bus_txn_count", exp_q.size(), 0);
      for (int i = 1; i < bp; i++) begin
         @(negedge i_clk);
         check("bp_valid_held", o_rsp_valid, 1'b1);
         check("bp_result_held", o_rsp_result, er);
         check("bp_flags_held", o_rsp_flags, ef);
         check("bp_cmd_ready_low", o_cmd_ready, 1'b0);
      end
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      check("post_hs_valid_low", o_rsp_valid, 1'b0);
      check("post_hs_cmd_ready", o_cmd_ready, 1'b1);
      exp_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cmd_ready"}, o_cmd_ready, 1'b1);
      check({tag, "_rsp_valid"}, o_rsp_valid, 1'b0);
      check({tag, "_rsp_result"}, o_rsp_result, 8'h00);
      check({tag, "_rsp_flags"}, o_rsp_flags, 8'h00);
      check({tag, "_rsp_err"}, o_rsp_err, 1'b0);
      check({tag, "_wb_stb"}, o_wb_stb, 1'b0);
      check({tag, "_wb_we"}, o_wb_we, 1'b0);
      check({tag, "_wb_addr"}, o_wb_addr, 8'h00);
      check({tag, "_wb_data"}, o_wb_data, 8'h00);
   endtask

   typedef struct {
      logic       op;
      logic [7:0] a, b;
      int         s_idx, s_n, d_idx, d_n, bp;
      logic [7:0] res, flg;
      int         lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [7:0] er, ef;
      int         n, c, extra;
      logic       rop;
      logic [7:0] ra, rb;

      // carry chain: #1 sets carry, #2 consumes it and sets it again, #3 consumes it
      vecs[0] = '{1'b0, 8'h05, 8'h03, -1, 0, -1, 0, 0, 8'h08, 8'h00, 11};
      vecs[1] = '{1'b0, 8'h80, 8'h80, -1, 0, -1, 0, 0, 8'h00, 8'h03, 11};
      vecs[2] = '{1'b1, 8'hFF, 8'h00, -1, 0, -1, 0, 0, 8'h00, 8'h03, 11};
      vecs[3] = '{1'b1, 8'h10, 8'h20, -1, 0, -1, 0, 0, 8'h31, 8'h00, 11};
      vecs[4] = '{1'b0, 8'h05, 8'h03,  1, 3, -1, 0, 0, 8'h08, 8'h00, 14};
      vecs[5] = '{1'b0, 8'hFE, 8'h01, -1, 0, -1, 0, 5, 8'hFF, 8'h00, 11};
      vecs[6] = '{1'b1, 8'h01, 8'h01, -1, 0,  4, 2, 0, 8'h02, 8'h00, 13};

      reset = 1'b0;
      i_cmd_valid = 1'b0; i_cmd_op = 1'b0; i_cmd_a = 8'h00; i_cmd_b = 8'h00;
      i_rsp_ready = 1'b0;
      t_cmd_valid = 1'b0; t_cmd_op = 1'b0; t_cmd_a = 8'h00; t_cmd_b = 8'h00;
      t_rsp_ready = 1'b0;
      set_plan(-1, 0, -1, 0);

      repeat (3) @(negedge i_clk);
      check("in_reset_stb", o_wb_stb, 1'b0);
      check("in_reset_cmd_ready", o_cmd_ready, 1'b1);
      #2 reset = 1'b1;
      @(negedge i_clk);
      check_reset_values("reset");

      for (int i = 0; i < 7; i++) begin
         set_plan(vecs[i].s_idx, vecs[i].s_n, vecs[i].d_idx, vecs[i].d_n);
         model_cmd(vecs[i].op, vecs[i].a, vecs[i].b, er, ef);
         run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].bp, 1'b0,
                 vecs[i].res, vecs[i].flg, vecs[i].lat);
      end

      for (int k = 0; k < 40; k++) begin
         extra = 0;
         for (int i = 0; i < 5; i++) begin
            stall_plan[i] = $urandom_range(0, 3);
            delay_plan[i] = $urandom_range(0, 3);
            extra += stall_plan[i] + delay_plan[i];
         end
         rop = 1'($urandom_range(0, 1));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         model_cmd(rop, ra, rb, er, ef);
         run_cmd(rop, ra, rb, $urandom_range(0, 4), 1'($urandom_range(0, 1)), er, ef, 11 + extra);
      end

      // reset while the EXEC request is strobed (held by stalls)
      set_plan(2, 6, -1, 0);
      @(negedge i_clk);
      txn_idx = 0;
      push_exp(1'b0, 8'h11, 8'h22);
      i_cmd_valid = 1'b1; i_cmd_op = 1'b0; i_cmd_a = 8'h11; i_cmd_b = 8'h22;
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      n = 0;
      while (!(o_wb_stb && o_wb_addr == 8'h80) && n < 30) begin
         @(negedge i_clk);
         n++;
      end
      check("exec_stb_seen", (o_wb_stb && o_wb_addr == 8'h80), 1'b1);
      #2 reset = 1'b0;
      #1 check("reset_async_stb", o_wb_stb, 1'b0);
      check("reset_async_rsp_valid", o_rsp_valid, 1'b0);
      @(negedge i_clk);
      #2 reset = 1'b1;
      exp_q.delete();
      @(negedge i_clk);
      check_reset_values("post_midop_reset");
      set_plan(-1, 0, -1, 0);
      model_cmd(1'b0, 8'h11, 8'h22, er, ef);
      run_cmd(1'b0, 8'h11, 8'h22, 0, 1'b0, er, ef, 11);

      // ACK_TIMEOUT=4 instance: a nominal command, then a missing result ack
      t_block_res = 0;
      @(negedge i_clk);
      t_cmd_valid = 1'b1; t_cmd_a = 8'h01; t_cmd_b = 8'h02; t_cmd_op = 1'b0;
      @(negedge i_clk);
      t_cmd_valid = 1'b0;
      n = 0;
      while (!t_rsp_valid && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check("t4_nominal_valid", t_rsp_valid, 1'b1);
      check("t4_nominal_err", t_rsp_err, 1'b0);
      check("t4_nominal_result", t_rsp_result, 8'h5A);
      check("t4_nominal_flags", t_rsp_flags, 8'h5A);
      t_rsp_ready = 1'b1;
      @(negedge i_clk);
      t_rsp_ready = 1'b0;

      t_block_res = 1;
      @(negedge i_clk);
      t_cmd_valid = 1'b1;
      @(negedge i_clk);
      t_cmd_valid = 1'b0;
      n = 0;
      while (!(t_stb && t_addr == 8'h03) && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check("t4_rdres_seen", (t_stb && t_addr == 8'h03), 1'b1);
      c = cyc;
      for (int i = 1; i < 4; i++) begin
         @(negedge i_clk);
         check("t4_stb_dropped", t_stb, 1'b0);
         check("t4_no_early_rsp", t_rsp_valid, 1'b0);
      end
      @(negedge i_clk);
      check("t4_timeout_cycle", cyc - c, 4);
      check("t4_timeout_valid", t_rsp_valid, 1'b1);
      check("t4_timeout_err", t_rsp_err, 1'b1);
      check("t4_timeout_result", t_rsp_result, 8'h00);
      check("t4_timeout_flags", t_rsp_flags, 8'h00);
      check("t4_timeout_cmd_ready", t_cmd_ready, 1'b0);
      t_rsp_ready = 1'b1;
      @(negedge i_clk);
      t_rsp_ready = 1'b0;
      check("t4_post_hs_cmd_ready", t_cmd_ready, 1'b1);
      check("t4_post_hs_valid", t_rsp_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
